// File: rtl/uart_apb_sequencer_if.sv
// Signal bundle between the UART APB sequencer and its neighbours: the APB
// register port toward uart_wraper plus the core-side TX/RX byte streams.
interface uart_apb_sequencer_if;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic [31:0] prdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstb;
  logic        pready;
  logic        perr;

  // Stream handshake: a byte moves on a cycle where valid and ready are both
  // high. TX: tx_ready is a one-cycle pulse when the THR write for tx_data
  // completes. RX: rx_valid/rx_data hold until the consumer raises rx_ready.
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  logic        init_done;
  logic        err;

  modport master (
    output paddr, pdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready,
    output init_done, err
  );

  modport slave (
    input  paddr, pdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready,
    input  init_done, err
  );
endinterface

// File: rtl/uart_apb_sequencer.sv
// APB master for the 16550 wrapper: programs the UART after reset, then polls LSR
// and shares the register port between a TX byte stream and an RX byte stream.
module uart_apb_sequencer #(
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'h07
) (
  input  logic                    APB_PCLK,
  input  logic                    APB_PRESET,
  uart_apb_sequencer_if.master    bus,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_POLL   = 3'd1,
    S_DECIDE = 3'd2,
    S_TX     = 3'd3,
    S_RX     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } phase_t;

  localparam logic [2:0] REG_RBR_THR = 3'd0;
  localparam logic [2:0] REG_LSR     = 3'd5;

  state_t     state;
  phase_t     phase;
  logic [2:0] step;
  logic       prio_rx;
  logic [7:0] lsr;
  logic [2:0] paddr_q;
  logic [7:0] pdata_q;
  logic       psel_q;
  logic       penable_q;
  logic       pwrite_q;
  logic       init_done_q;
  logic       err_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;

  logic       done;
  logic       rx_ok;
  logic       tx_ok;
  logic       serve_rx;
  logic       serve_tx;
  logic       unused_prdata;

  // Init write list as {register offset, data}; DLAB is set for the divisor
  // writes and cleared again before FCR/IER.
  function automatic logic [10:0] init_cmd(input logic [2:0] s);
    logic [10:0] cmd;
    cmd = {3'd3, 8'h80 | LCR_VAL};
    case (s)
      3'd0:    cmd = {3'd3, 8'h80 | LCR_VAL};
      3'd1:    cmd = {3'd0, DIVISOR[7:0]};
      3'd2:    cmd = {3'd1, DIVISOR[15:8]};
      3'd3:    cmd = {3'd3, LCR_VAL & 8'h7F};
      3'd4:    cmd = {3'd2, FCR_VAL};
      default: cmd = {3'd1, 8'h00};
    endcase
    return cmd;
  endfunction

  assign done     = (phase == PH_ACCESS) && bus.pready;
  assign rx_ok    = lsr[0] && !rx_valid_q;
  assign tx_ok    = lsr[5] && bus.tx_valid && init_done_q;
  assign serve_rx = rx_ok && (!tx_ok || prio_rx);
  assign serve_tx = tx_ok && !serve_rx;

  always_ff @(posedge APB_PCLK or posedge APB_PRESET) begin
    if (APB_PRESET) begin
      state       <= S_INIT;
      phase       <= PH_IDLE;
      step        <= 3'd0;
      prio_rx     <= 1'b1;
      lsr         <= 8'h00;
      paddr_q     <= 3'd0;
      pdata_q     <= 8'h00;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
    end else begin
      if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;

      case (phase)
        PH_SETUP: begin
          penable_q <= 1'b1;
          phase     <= PH_ACCESS;
        end

        PH_ACCESS: begin
          if (bus.pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            phase     <= PH_IDLE;
            if (bus.perr) err_q <= 1'b1;
            case (state)
              S_INIT: begin
                if (step == 3'd5) begin
                  init_done_q <= 1'b1;
                  state       <= S_POLL;
                end else begin
                  step <= step + 3'd1;
                end
              end
              // An errored LSR read carries no status, so nothing gets serviced.
              S_POLL: begin
                lsr   <= bus.perr ? 8'h00 : bus.prdata[7:0];
                state <= S_DECIDE;
              end
              S_RX: begin
                if (!bus.perr) begin
                  rx_data_q  <= bus.prdata[7:0];
                  rx_valid_q <= 1'b1;
                end
                state <= S_POLL;
              end
              default: state <= S_POLL;
            endcase
          end
        end

        default: begin
          case (state)
            S_INIT: begin
              {paddr_q, pdata_q} <= init_cmd(step);
              pwrite_q <= 1'b1;
              psel_q   <= 1'b1;
              phase    <= PH_SETUP;
            end
            S_POLL: begin
              paddr_q  <= REG_LSR;
              pdata_q  <= 8'h00;
              pwrite_q <= 1'b0;
              psel_q   <= 1'b1;
              phase    <= PH_SETUP;
            end
            // Priority only rotates when both sides were eligible in this decision.
            S_DECIDE: begin
              if (rx_ok && tx_ok) prio_rx <= !prio_rx;
              if (serve_rx) begin
                paddr_q  <= REG_RBR_THR;
                pdata_q  <= 8'h00;
                pwrite_q <= 1'b0;
                psel_q   <= 1'b1;
                phase    <= PH_SETUP;
                state    <= S_RX;
              end else if (serve_tx) begin
                paddr_q  <= REG_RBR_THR;
                pdata_q  <= bus.tx_data;
                pwrite_q <= 1'b1;
                psel_q   <= 1'b1;
                phase    <= PH_SETUP;
                state    <= S_TX;
              end else begin
                state <= S_POLL;
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign bus.paddr     = {29'd0, paddr_q};
  assign bus.pdata     = {24'd0, pdata_q};
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pstb      = (psel_q && pwrite_q) ? 4'b0001 : 4'b0000;
  assign bus.tx_ready  = (state == S_TX) && done;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.init_done = init_done_q;
  assign bus.err       = err_q;
  assign dbg_state     = state;
  assign unused_prdata = ^bus.prdata[31:8];

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer: an APB register-port model with wait
// states and error injection, a TX byte source and an RX byte sink.
module tb_uart_apb_sequencer;

  logic clk;
  logic rst;
  logic [2:0] dbg_state;

  uart_apb_sequencer_if bus ();

  uart_apb_sequencer dut (
    .APB_PCLK   (clk),
    .APB_PRESET (rst),
    .bus        (bus),
    .dbg_state  (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transactions packed as {pwrite, pstb, addr[2:0], data[7:0]}.
  localparam int W = 16;

  typedef struct {
    logic [7:0] lsr;
    bit         push_tx;
    logic [7:0] tx_byte;
    bit         push_rx;
    logic [7:0] rx_byte;
    int         kind;      // 0 no service, 1 THR write, 2 RBR read
    logic [W-1:0] exp_txn;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] all_q[$];
  logic [W-1:0] svc_q[$];
  logic [W-1:0] exp_q[$];
  logic [7:0]   rbr_q[$];
  logic [7:0]   tx_src_q[$];
  logic [7:0]   rx_got_q[$];
  int           gap_q[$];

  logic [7:0] lsr_val = 8'h00;
  int   wait_n   = 0;
  bit   perr_thr = 1'b0;
  int   acc_cnt  = 0;
  int   stab_err = 0;
  int   upper_err = 0;
  int   tx_cnt   = 0;
  int   low_run  = 0;
  int   hi_run   = 0;
  int   last_hi  = 0;
  logic [31:0] cap_addr, cap_data;
  logic        cap_wr;
  logic [3:0]  cap_strb;

  vec_t         vecs[5];
  logic [W-1:0] init_tab[6];

  function automatic logic [W-1:0] wr_txn(input logic [2:0] a, input logic [7:0] d);
    return {1'b1, 4'b0001, a, d};
  endfunction

  function automatic logic [W-1:0] rd_txn(input logic [2:0] a, input logic [7:0] d);
    return {1'b0, 4'b0000, a, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // APB register-port model: records completed transfers and checks that the
  // request fields do not move while the access is stretched.
  always @(negedge clk) begin
    logic [7:0] rd;
    if (bus.psel) begin
      if (low_run > 0) gap_q.push_back(low_run);
      low_run = 0;
      hi_run++;
    end else begin
      if (hi_run > 0) last_hi = hi_run;
      hi_run = 0;
      low_run++;
    end
    if (rst) begin
      bus.pready = 1'b0;
      bus.perr   = 1'b0;
      acc_cnt    = 0;
    end else if (bus.psel && bus.penable) begin
      if (bus.paddr !== cap_addr || bus.pdata !== cap_data ||
          bus.pwrite !== cap_wr || bus.pstb !== cap_strb) stab_err++;
      if (acc_cnt < wait_n) begin
        bus.pready = 1'b0;
        acc_cnt++;
      end else begin
        rd = 8'h00;
        if (!bus.pwrite) begin
          if (bus.paddr[2:0] == 3'd5) rd = lsr_val;
          else if (rbr_q.size() > 0) rd = rbr_q.pop_front();
        end
        bus.pready = 1'b1;
        bus.perr   = bus.pwrite && (bus.paddr[2:0] == 3'd0) && perr_thr;
        bus.prdata = {24'h0, rd};
        if (bus.paddr[31:3] != 0 || bus.pdata[31:8] != 0) upper_err++;
        all_q.push_back({bus.pwrite, bus.pstb, bus.paddr[2:0],
                         bus.pwrite ? bus.pdata[7:0] : rd});
        if (bus.pwrite || bus.paddr[2:0] != 3'd5)
          svc_q.push_back({bus.pwrite, bus.pstb, bus.paddr[2:0],
                           bus.pwrite ? bus.pdata[7:0] : rd});
      end
    end else begin
      bus.pready = 1'b0;
      bus.perr   = 1'b0;
      acc_cnt    = 0;
      if (bus.psel) begin
        cap_addr = bus.paddr;
        cap_data = bus.pdata;
        cap_wr   = bus.pwrite;
        cap_strb = bus.pstb;
      end
    end
  end

  // Stream side: TX source advances on tx_ready, RX sink collects accepted bytes.
  always @(negedge clk) begin
    logic [7:0] tmp;
    #3;
    if (bus.tx_ready) begin
      tx_cnt++;
      if (tx_src_q.size() > 0) tmp = tx_src_q.pop_front();
      if (tx_src_q.size() > 0) bus.tx_data = tx_src_q[0];
      else bus.tx_valid = 1'b0;
    end
    if (bus.rx_valid && bus.rx_ready) rx_got_q.push_back(bus.rx_data);
  end

  task automatic push_tx(input logic [7:0] b);
    tx_src_q.push_back(b);
    if (!bus.tx_valid) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = b;
    end
  endtask

  task automatic quiesce();
    lsr_val = 8'h00;
    tx_src_q.delete();
    bus.tx_valid = 1'b0;
    rbr_q.delete();
    repeat (15) @(negedge clk);
    svc_q.delete();
    rx_got_q.delete();
  endtask

  function automatic int count_reads();
    int n = 0;
    foreach (svc_q[i]) if (!svc_q[i][W-1]) n++;
    return n;
  endfunction

  task automatic run_init_check(input string tag);
    int n = 0;
    while (!bus.init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_init_done"}, bus.init_done, 1'b1);
    repeat (6) @(negedge clk);
    check({tag, "_txn_count_ge7"}, all_q.size() >= 7, 1'b1);
    if (all_q.size() >= 7) begin
      for (int i = 0; i < 6; i++)
        check($sformatf("%s_write%0d", tag, i), all_q[i], init_tab[i]);
      check({tag, "_first_poll"}, all_q[6], rd_txn(3'd5, 8'h00));
    end
    check({tag, "_gap_count"}, gap_q.size() >= 6, 1'b1);
    if (gap_q.size() >= 6)
      for (int i = 1; i < 6; i++)
        check($sformatf("%s_gap%0d", tag, i), gap_q[i], 1);
  endtask

  initial begin
    int n;
    int base;
    bit found;

    init_tab[0] = wr_txn(3'd3, 8'h83);
    init_tab[1] = wr_txn(3'd0, 8'h1B);
    init_tab[2] = wr_txn(3'd1, 8'h00);
    init_tab[3] = wr_txn(3'd3, 8'h03);
    init_tab[4] = wr_txn(3'd2, 8'h07);
    init_tab[5] = wr_txn(3'd1, 8'h00);

    // THR writable with byte 0x55 already pending since before init.
    vecs[0] = '{lsr: 8'h60, push_tx: 0, tx_byte: 8'h00, push_rx: 0, rx_byte: 8'h00,
                kind: 1, exp_txn: wr_txn(3'd0, 8'h55)};
    vecs[1] = '{lsr: 8'h00, push_tx: 1, tx_byte: 8'h42, push_rx: 0, rx_byte: 8'h00,
                kind: 0, exp_txn: '0};
    vecs[2] = '{lsr: 8'h20, push_tx: 1, tx_byte: 8'h42, push_rx: 0, rx_byte: 8'h00,
                kind: 1, exp_txn: wr_txn(3'd0, 8'h42)};
    vecs[3] = '{lsr: 8'h01, push_tx: 0, tx_byte: 8'h00, push_rx: 1, rx_byte: 8'h5A,
                kind: 2, exp_txn: rd_txn(3'd0, 8'h5A)};
    vecs[4] = '{lsr: 8'h40, push_tx: 1, tx_byte: 8'h24, push_rx: 0, rx_byte: 8'h00,
                kind: 0, exp_txn: '0};

    rst          = 1'b1;
    bus.pready   = 1'b0;
    bus.perr     = 1'b0;
    bus.prdata   = 32'h0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.rx_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_psel",      bus.psel, 1'b0);
    check("rst_penable",   bus.penable, 1'b0);
    check("rst_pwrite",    bus.pwrite, 1'b0);
    check("rst_pstb",      bus.pstb, 4'b0000);
    check("rst_paddr",     bus.paddr, 32'h0);
    check("rst_pdata",     bus.pdata, 32'h0);
    check("rst_tx_ready",  bus.tx_ready, 1'b0);
    check("rst_rx_valid",  bus.rx_valid, 1'b0);
    check("rst_rx_data",   bus.rx_data, 8'h00);
    check("rst_init_done", bus.init_done, 1'b0);
    check("rst_err",       bus.err, 1'b0);

    push_tx(8'h55);
    rst = 1'b0;
    run_init_check("init");
    check("pre_init_tx_ignored", tx_cnt, 0);
    check("post_init_rx_valid", bus.rx_valid, 1'b0);
    svc_q.delete();
    for (int i = 0; i < 6 && all_q.size() > 0; i++) n = 0;

    // Single-poll decision vectors.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      svc_q.delete();
      rx_got_q.delete();
      base = tx_cnt;
      if (vecs[v].push_rx) rbr_q.push_back(vecs[v].rx_byte);
      if (vecs[v].push_tx) push_tx(vecs[v].tx_byte);
      lsr_val = vecs[v].lsr;
      repeat (30) @(negedge clk);
      if (vecs[v].kind == 0) begin
        check($sformatf("vec%0d_no_service", v), svc_q.size(), 0);
        check($sformatf("vec%0d_no_tx_ready", v), tx_cnt - base, 0);
      end else begin
        check($sformatf("vec%0d_service_seen", v), svc_q.size() >= 1, 1'b1);
        if (svc_q.size() >= 1)
          check($sformatf("vec%0d_txn", v), svc_q[0], vecs[v].exp_txn);
        if (vecs[v].kind == 1)
          check($sformatf("vec%0d_tx_ready_pulses", v), tx_cnt - base, 1);
        else begin
          check($sformatf("vec%0d_rx_got", v), rx_got_q.size() >= 1, 1'b1);
          if (rx_got_q.size() >= 1)
            check($sformatf("vec%0d_rx_byte", v), rx_got_q[0], vecs[v].rx_byte);
        end
      end
      quiesce();
    end

    // RX backpressure: byte held, no further RBR reads, TX still served.
    @(negedge clk);
    bus.rx_ready = 1'b0;
    rbr_q.push_back(8'hA5);
    rbr_q.push_back(8'h3C);
    lsr_val = 8'h01;
    n = 0;
    while (!bus.rx_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("bp_rx_valid", bus.rx_valid, 1'b1);
    check("bp_rx_data", bus.rx_data, 8'hA5);
    repeat (30) @(negedge clk);
    check("bp_rx_valid_held", bus.rx_valid, 1'b1);
    check("bp_rx_data_held", bus.rx_data, 8'hA5);
    check("bp_single_rbr_read", count_reads(), 1);
    base = tx_cnt;
    lsr_val = 8'h21;
    push_tx(8'h11);
    push_tx(8'h22);
    n = 0;
    while (tx_cnt < base + 2 && n < 150) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("bp_tx_served", tx_cnt - base, 2);
    check("bp_still_one_read", count_reads(), 1);
    check("bp_svc_count", svc_q.size(), 3);
    if (svc_q.size() == 3) begin
      check("bp_tx_first", svc_q[1], wr_txn(3'd0, 8'h11));
      check("bp_tx_second", svc_q[2], wr_txn(3'd0, 8'h22));
    end
    lsr_val = 8'h01;
    bus.rx_ready = 1'b1;
    n = 0;
    while (rx_got_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_drain_count", rx_got_q.size() >= 2, 1'b1);
    if (rx_got_q.size() >= 2) begin
      check("bp_drain_first", rx_got_q[0], 8'hA5);
      check("bp_drain_second", rx_got_q[1], 8'h3C);
    end
    quiesce();

    // Both sides eligible on every poll: service alternates starting with RX.
    @(negedge clk);
    rbr_q.push_back(8'h10);
    rbr_q.push_back(8'h20);
    push_tx(8'hA1);
    push_tx(8'hA2);
    lsr_val = 8'h61;
    exp_q.push_back(rd_txn(3'd0, 8'h10));
    exp_q.push_back(wr_txn(3'd0, 8'hA1));
    exp_q.push_back(rd_txn(3'd0, 8'h20));
    exp_q.push_back(wr_txn(3'd0, 8'hA2));
    n = 0;
    while (svc_q.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lsr_val = 8'h00;
    check("alt_svc_count", svc_q.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < svc_q.size(); i++)
      check($sformatf("alt_order%0d", i), svc_q[i], exp_q[i]);
    exp_q.delete();
    repeat (10) @(negedge clk);
    check("alt_rx_got_count", rx_got_q.size() >= 2, 1'b1);
    if (rx_got_q.size() >= 2) begin
      check("alt_rx_first", rx_got_q[0], 8'h10);
      check("alt_rx_second", rx_got_q[1], 8'h20);
    end
    quiesce();

    // Wait states with a slave error on the THR write.
    check("err_clear_before", bus.err, 1'b0);
    @(negedge clk);
    wait_n   = 3;
    perr_thr = 1'b1;
    stab_err = 0;
    base     = tx_cnt;
    push_tx(8'h77);
    lsr_val = 8'h20;
    n = 0;
    while (tx_cnt == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    lsr_val = 8'h00;
    repeat (2) @(negedge clk);
    check("ws_tx_ready_once", tx_cnt - base, 1);
    check("ws_psel_len", last_hi, 5);
    check("ws_stable", stab_err, 0);
    check("ws_err_set", bus.err, 1'b1);
    check("ws_svc_count", svc_q.size(), 1);
    if (svc_q.size() == 1) check("ws_thr_txn", svc_q[0], wr_txn(3'd0, 8'h77));
    perr_thr = 1'b0;
    repeat (20) @(negedge clk);
    check("ws_err_sticky", bus.err, 1'b1);
    wait_n = 0;
    quiesce();

    // Reset during the access phase of a THR write.
    @(negedge clk);
    wait_n = 6;
    base   = tx_cnt;
    push_tx(8'h99);
    lsr_val = 8'h20;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.psel && bus.penable && bus.pwrite && bus.paddr[2:0] == 3'd0) found = 1'b1;
    end
    check("rr_thr_access_seen", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rr_psel_async", bus.psel, 1'b0);
    check("rr_penable_async", bus.penable, 1'b0);
    check("rr_err_cleared", bus.err, 1'b0);
    wait_n  = 0;
    lsr_val = 8'h00;
    tx_src_q.delete();
    bus.tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rr_no_tx_ready", tx_cnt - base, 0);
    check("rr_init_done_low", bus.init_done, 1'b0);
    all_q.delete();
    svc_q.delete();
    gap_q.delete();
    rst = 1'b0;
    run_init_check("reinit");

    check("bus_stable_overall", stab_err, 0);
    check("upper_bits_zero", upper_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
